utrap_csr: RTL

User-level trap and CSR unit for the single-cycle RV32 core: holds the N-extension user CSRs and 64-bit cycle/instret counters, and arbitrates exceptions and synchronised interrupts. It produces the `trap`, trap-target and `epc` values that the program-counter register samples on the next clock edge. It sits between decode/execute (exception flags, CSR access) and the PC register.

---
 rtl/utrap_pkg.sv | 26 ++
 rtl/utrap_csr_irq_sync.sv | 15 +
 rtl/utrap_csr.sv | 117 +++++++++++
 3 files changed

// File: rtl/utrap_pkg.sv
// utrap_pkg: CSR addresses, cause codes, csr_op encodings and utvec modes for utrap_csr
package utrap_pkg;
  localparam logic [11:0] A_USTATUS  = 12'h000;
  localparam logic [11:0] A_UIE      = 12'h004;
  localparam logic [11:0] A_UTVEC    = 12'h005;
  localparam logic [11:0] A_USCRATCH = 12'h040;
  localparam logic [11:0] A_UEPC     = 12'h041;
  localparam logic [11:0] A_UCAUSE   = 12'h042;
  localparam logic [11:0] A_UTVAL    = 12'h043;
  localparam logic [11:0] A_UIP      = 12'h044;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  typedef enum logic [1:0] {CSR_NONE = 2'b00, CSR_RW = 2'b01, CSR_RS = 2'b10, CSR_RC = 2'b11} csr_op_e;
  localparam logic [3:0] C_FETCH_MIS = 4'd0;
  localparam logic [3:0] C_ILLEGAL   = 4'd2;
  localparam logic [3:0] C_LOAD_MIS  = 4'd4;
  localparam logic [3:0] C_STORE_MIS = 4'd6;
  localparam logic [3:0] C_ECALL     = 4'd8;
  localparam logic [3:0] C_USI       = 4'd0;
  localparam logic [3:0] C_UTI       = 4'd4;
  localparam logic [3:0] C_UEI       = 4'd8;
  localparam logic [1:0] MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MODE_VECTORED = 2'd1;
endpackage

// File: rtl/utrap_csr_irq_sync.sv
// irq_sync: multi-flop synchroniser for one asynchronous interrupt line
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/utrap_csr.sv
// utrap_csr: user-level CSRs, counters and exception/interrupt trap arbitration
module utrap_csr
  import utrap_pkg::*;
#(
  parameter logic [31:0] RESET_UTVEC = 32'h0040_0004,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        ecall,
  input  logic        illegal,
  input  logic        fetch_misalign,
  input  logic        load_misalign,
  input  logic        store_misalign,
  input  logic [31:0] mem_addr,
  input  logic        uret,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic        trap,
  output logic [31:0] utvec,
  output logic [31:0] epc
);
  logic utip, ueip, st_uie, st_upie, usip;
  logic [2:0] ie;
  logic [31:0] tvec, scratch, uepc, ucause, utval_r, wval, tval;
  logic [63:0] cycle, instret;
  logic known, ro, wr_req, we, ill, exc, int_ext, int_sw, int_tm, intr_pend;
  logic [3:0] exc_code, int_code, code;
  irq_sync #(.STAGES(SYNC_STAGES)) u_tsync (.clk(clk), .rst(rst), .d(irq_timer), .q(utip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_esync (.clk(clk), .rst(rst), .d(irq_ext), .q(ueip));
  always_comb begin
    known = 1'b1;
    ro = 1'b0;
    csr_rdata = '0;
    case (csr_addr)
      A_USTATUS:  csr_rdata = {27'd0, st_upie, 3'd0, st_uie};
      A_UIE:      csr_rdata = {23'd0, ie[2], 3'd0, ie[1], 3'd0, ie[0]};
      A_UTVEC:    csr_rdata = tvec;
      A_USCRATCH: csr_rdata = scratch;
      A_UEPC:     csr_rdata = {uepc[31:2], 2'b00};
      A_UCAUSE:   csr_rdata = ucause;
      A_UTVAL:    csr_rdata = utval_r;
      A_UIP:      csr_rdata = {23'd0, ueip, 3'd0, utip, 3'd0, usip};
      A_CYCLE:    begin csr_rdata = cycle[31:0];    ro = 1'b1; end
      A_CYCLEH:   begin csr_rdata = cycle[63:32];   ro = 1'b1; end
      A_INSTRET:  begin csr_rdata = instret[31:0];  ro = 1'b1; end
      A_INSTRETH: begin csr_rdata = instret[63:32]; ro = 1'b1; end
      default:    known = 1'b0;
    endcase
  end
  assign wr_req = csr_op == CSR_RW || (csr_op != CSR_NONE && csr_wdata != '0);
  assign csr_illegal = instr_valid & wr_req & (!known | ro);
  assign wval = csr_op == CSR_RW ? csr_wdata : csr_op == CSR_RS ? csr_rdata | csr_wdata : csr_rdata & ~csr_wdata;
  assign ill = illegal | csr_illegal;
  assign exc = fetch_misalign | ill | ecall | load_misalign | store_misalign;
  assign exc_code = fetch_misalign ? C_FETCH_MIS : ill ? C_ILLEGAL : ecall ? C_ECALL : load_misalign ? C_LOAD_MIS : C_STORE_MIS;
  assign int_ext = ueip & ie[2];
  assign int_sw = usip & ie[0];
  assign int_tm = utip & ie[1];
  assign intr_pend = instr_valid & st_uie & (int_ext | int_sw | int_tm);
  assign int_code = int_ext ? C_UEI : int_sw ? C_USI : C_UTI;
  assign code = exc ? exc_code : int_code;
  assign trap = instr_valid & (exc | intr_pend);
  assign tval = !exc ? 32'd0 : fetch_misalign ? pc : ill ? instr : ecall ? 32'd0 : mem_addr;
  assign utvec = {tvec[31:2], 2'b00} + ((intr_pend && !exc && tvec[1:0] == MODE_VECTORED) ? {26'd0, code, 2'b00} : 32'd0);
  assign epc = {uepc[31:2], 2'b00};
  assign we = instr_valid & wr_req & !csr_illegal & !trap;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_uie <= 1'b0;
      st_upie <= 1'b0;
      usip <= 1'b0;
      ie <= '0;
      tvec <= RESET_UTVEC;
      scratch <= '0;
      uepc <= '0;
      ucause <= '0;
      utval_r <= '0;
      cycle <= '0;
      instret <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (instr_valid && !trap) instret <= instret + 64'd1;
      if (trap) begin
        uepc <= pc;
        ucause <= {!exc, 27'd0, code};
        utval_r <= tval;
        st_upie <= st_uie;
        st_uie <= 1'b0;
      end else begin
        if (we)
          case (csr_addr)
            A_USTATUS:  begin st_uie <= wval[0]; st_upie <= wval[4]; end
            A_UIE:      ie <= {wval[8], wval[4], wval[0]};
            A_UTVEC:    tvec <= {wval[31:2], wval[1] ? MODE_DIRECT : wval[1:0]};
            A_USCRATCH: scratch <= wval;
            A_UEPC:     uepc <= wval;
            A_UCAUSE:   ucause <= wval;
            A_UTVAL:    utval_r <= wval;
            A_UIP:      usip <= wval[0];
            default:    ;
          endcase
        if (instr_valid && uret) begin
          st_uie <= st_upie;
          st_upie <= 1'b1;
        end
      end
    end
endmodule
